dcache_mem_responder: RTL and testbench
=======================================

// Module: dcache_mem_responder
// PURPOSE
// - Main-memory side of the D-cache memory port: serves single-word refill reads (mem_r)
//   and dirty-line writebacks (mem_w) issued by the data cache.
// - Word-addressed backing RAM with a fixed, parameterised access latency.
// - Signals completion with a one-cycle mem_ready pulse. Used in simulation and on FPGA
//   as the memory behind the cache.
// PARAMETERS
// - ADDR_W   10  word-index width; RAM depth = 2**ADDR_W 32-bit words
// - LATENCY  4   cycles from request acceptance to mem_ready; legal range 1..255
// PORTS
// - clk        in   1   clock, all logic on posedge
// - rstn       in   1   reset, synchronous, active-low
// - mem_r      in   1   read request, held by the cache until mem_ready
// - mem_w      in   1   write request, held by the cache until mem_ready
// - mem_addr   in   32  byte address; index = mem_addr[ADDR_W+1:2]
// - dirty_mem  in   32  write data, valid while mem_w is high
// - mem_data   out  32  read data, valid in the mem_ready cycle of a read
// - mem_ready  out  1   one-cycle completion pulse
// - stat_rd_cnt out 32  completed reads (MEM_STATS_EN only)
// - stat_wr_cnt out 32  completed writes (MEM_STATS_EN only)
// BEHAVIOUR
// - Reset: state=IDLE, mem_ready=0, mem_data=0, latency counter=0, stats=0.
//   RAM contents are not cleared.
// - FSM: IDLE -> BUSY -> RESP -> IDLE.
// - IDLE: at a posedge with mem_w|mem_r high, latch index, dirty_mem and op, load
//   cnt=LATENCY-1, go BUSY. If LATENCY=1, go straight to RESP.
// - Simultaneous mem_w and mem_r: the write wins; the read stays pending and is accepted
//   from IDLE after the write completes.
// - BUSY: decrement cnt each cycle; go to RESP when cnt reaches 1. Request inputs are
//   ignored, and a dropped request does not abort the access.
// - RESP (exactly 1 cycle): mem_ready=1.
//   - Write: RAM[idx] <= latched data at the posedge ending RESP.
//   - Read: mem_data = RAM[idx] registered on entry to RESP and held afterwards until
//     the next read response.
//   - Requests are ignored in RESP; the next state is always IDLE.
// - Timing: accept at edge T, so mem_ready is high in the cycle after edge T+LATENCY-1,
//   i.e. LATENCY cycles after acceptance.
// - Minimum back-to-back spacing: LATENCY+1 cycles per access.
// - A request still high in the cycle after RESP is a new request.
// - Read-after-write to the same index returns the new data.
// - Address: bits [1:0] and bits above ADDR_W+1 are ignored, so addresses alias modulo
//   the RAM depth.
// - Reset mid-access: back to IDLE, no mem_ready, and a pending write is discarded
//   (RAM unchanged).
// CONFIGURATION
// - `define MEM_STATS_EN:
//   - stat_rd_cnt / stat_wr_cnt increment by 1 in each read/write RESP cycle.
//   - They wrap at 2**32 and reset to 0.
// - Without it: no counter flops; stat_rd_cnt and stat_wr_cnt are tied to 0, so the
//   port list is identical.
// TESTING
// - LATENCY=4: write 0xDEADBEEF to 0x0000_0040, then read 0x40 -> mem_ready pulses 4
//   cycles after each accept, mem_data=0xDEADBEEF on the read pulse.
// - mem_r and mem_w both high, addr 0x80, data 0x12345678 -> write completes first,
//   then the read returns 0x12345678; exactly two mem_ready pulses.
// - Drop mem_r after 1 cycle of BUSY -> mem_ready still pulses once at LATENCY,
//   no second pulse.
// - Write 0xA5A5A5A5 to addr 0x0000_1004 (ADDR_W=10) -> a read at 0x0000_0004 returns
//   0xA5A5A5A5 (alias).
// - rstn=0 during BUSY of a write of 0x1 to 0x10 (RAM[0x10] was 0x7) -> mem_ready stays
//   0, state IDLE, a later read of 0x10 returns 0x7.
// - LATENCY=1 with MEM_STATS_EN: 3 reads + 2 writes back-to-back -> ready 1 cycle after
//   each accept, stat_rd_cnt=3, stat_wr_cnt=2.

Source files
------------

// File: rtl/dcache_mem_responder_if.sv
// ---------------------------------------------------------------------------
// dcache_mem_responder_if
// Purpose : request/response bundle between the data cache (master) and the
//           main-memory responder (slave).
// Signals :
//   mem_r      cache -> mem  read request, held until mem_ready
//   mem_w      cache -> mem  write request, held until mem_ready
//   mem_addr   cache -> mem  byte address
//   dirty_mem  cache -> mem  write data, valid while mem_w is high
//   mem_data   mem -> cache  read data, valid in the mem_ready cycle of a read
//   mem_ready  mem -> cache  one-cycle completion pulse
// ---------------------------------------------------------------------------
interface dcache_mem_responder_if;
  logic        mem_r;
  logic        mem_w;
  logic [31:0] mem_addr;
  logic [31:0] dirty_mem;
  logic [31:0] mem_data;
  logic        mem_ready;

  modport master (
    output mem_r, mem_w, mem_addr, dirty_mem,
    input  mem_data, mem_ready
  );

  modport slave (
    input  mem_r, mem_w, mem_addr, dirty_mem,
    output mem_data, mem_ready
  );
endinterface

// File: rtl/dcache_mem_responder.sv
// ---------------------------------------------------------------------------
// dcache_mem_responder
// Purpose : main-memory side of the D-cache memory port. Serves single-word
//           refill reads and dirty-line writebacks from a word-addressed RAM
//           with a fixed access latency, and signals completion with a
//           one-cycle mem_ready pulse.
// Parameters:
//   ADDR_W   word-index width, RAM depth = 2**ADDR_W words of 32 bits
//   LATENCY  cycles from request acceptance to mem_ready (1..255)
// Ports:
//   clk          clock, all logic on posedge
//   rstn         synchronous active-low reset
//   bus          dcache_mem_responder_if.slave (mem_r, mem_w, mem_addr,
//                dirty_mem in; mem_data, mem_ready out)
//   stat_rd_cnt  completed reads  (counts only with MEM_STATS_EN)
//   stat_wr_cnt  completed writes (counts only with MEM_STATS_EN)
// Configuration:
//   `define MEM_STATS_EN enables the completion counters; without it both
//   stat outputs are tied to zero and no counter flops exist.
// ---------------------------------------------------------------------------
module dcache_mem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 4
) (
  input  logic                         clk,
  input  logic                         rstn,
  dcache_mem_responder_if.slave        bus,
  output logic [31:0]                  stat_rd_cnt,
  output logic [31:0]                  stat_wr_cnt
);

  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [7:0]        r_cnt;
  logic [7:0]        w_cnt_nxt;
  logic              w_accept;

  logic [ADDR_W-1:0] r_idx;
  logic [31:0]       r_wdata;
  logic              r_is_wr;
  logic [31:0]       r_mem_data;
  logic [31:0]       r_ram [0:(1<<ADDR_W)-1];

  logic [ADDR_W-1:0] w_idx_cur;
  logic              w_wr_cur;
  logic              w_enter_resp;
  logic              w_unused_addr;

  // Byte offset and bits above the index are don't-care: addresses alias
  // modulo the RAM depth.
  assign w_unused_addr = ^{bus.mem_addr[31:ADDR_W+2], bus.mem_addr[1:0]};

  // Next-state logic. Write has priority when both requests are high; the
  // read stays asserted by the cache and is picked up from IDLE later.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.mem_w | bus.mem_r) begin
          w_accept    = 1'b1;
          w_cnt_nxt   = LAT_M1;
          w_state_nxt = (LATENCY == 1) ? S_RESP : S_BUSY;
        end
      end
      S_BUSY: begin
        // Requests are ignored here, so a dropped request cannot abort.
        w_cnt_nxt = r_cnt - 8'd1;
        if (r_cnt == 8'd1) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Request capture; only meaningful while an access is in flight.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_idx   <= bus.mem_addr[ADDR_W+1:2];
      r_wdata <= bus.dirty_mem;
      r_is_wr <= bus.mem_w;
    end
  end

  // With LATENCY=1 RESP is entered straight from IDLE, before the request is
  // latched, so the index/op come from the bus in that case.
  assign w_idx_cur    = (r_state == S_IDLE) ? bus.mem_addr[ADDR_W+1:2] : r_idx;
  assign w_wr_cur     = (r_state == S_IDLE) ? bus.mem_w : r_is_wr;
  assign w_enter_resp = (w_state_nxt == S_RESP) && (r_state != S_RESP);

  // Read data is registered on entry to RESP and held until the next read
  // response.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_mem_data <= 32'd0;
    end else if (w_enter_resp && !w_wr_cur) begin
      r_mem_data <= r_ram[w_idx_cur];
    end
  end

  // Write commits at the edge ending RESP; a reset at that edge discards it.
  always_ff @(posedge clk) begin
    if (rstn && (r_state == S_RESP) && r_is_wr) begin
      r_ram[r_idx] <= r_wdata;
    end
  end

  assign bus.mem_ready = (r_state == S_RESP);
  assign bus.mem_data  = r_mem_data;

`ifdef MEM_STATS_EN
  logic [31:0] r_stat_rd;
  logic [31:0] r_stat_wr;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_stat_rd <= 32'd0;
      r_stat_wr <= 32'd0;
    end else if (r_state == S_RESP) begin
      if (r_is_wr) begin
        r_stat_wr <= r_stat_wr + 32'd1;
      end else begin
        r_stat_rd <= r_stat_rd + 32'd1;
      end
    end
  end

  assign stat_rd_cnt = r_stat_rd;
  assign stat_wr_cnt = r_stat_wr;
`else
  assign stat_rd_cnt = 32'd0;
  assign stat_wr_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_dcache_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_dcache_mem_responder
// Two responders (LATENCY=4 and LATENCY=1) share clock and reset. Each is
// driven as a cache would: raise a request, hold it until mem_ready, drop it.
// A word array per instance is the reference memory.
// ---------------------------------------------------------------------------
module tb_dcache_mem_responder;
  localparam int AW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn;

  dcache_mem_responder_if bus_a ();
  dcache_mem_responder_if bus_b ();

  logic        req_r [2];
  logic        req_w [2];
  logic [31:0] req_a [2];
  logic [31:0] req_d [2];
  logic        rdy   [2];
  logic [31:0] rdat  [2];
  logic [31:0] srd   [2];
  logic [31:0] swr   [2];

  assign bus_a.mem_r     = req_r[0];
  assign bus_a.mem_w     = req_w[0];
  assign bus_a.mem_addr  = req_a[0];
  assign bus_a.dirty_mem = req_d[0];
  assign rdy[0]          = bus_a.mem_ready;
  assign rdat[0]         = bus_a.mem_data;
  assign bus_b.mem_r     = req_r[1];
  assign bus_b.mem_w     = req_w[1];
  assign bus_b.mem_addr  = req_a[1];
  assign bus_b.dirty_mem = req_d[1];
  assign rdy[1]          = bus_b.mem_ready;
  assign rdat[1]         = bus_b.mem_data;

  dcache_mem_responder #(.ADDR_W(AW), .LATENCY(4)) u_lat4 (
    .clk(clk), .rstn(rstn), .bus(bus_a),
    .stat_rd_cnt(srd[0]), .stat_wr_cnt(swr[0])
  );
  dcache_mem_responder #(.ADDR_W(AW), .LATENCY(1)) u_lat1 (
    .clk(clk), .rstn(rstn), .bus(bus_b),
    .stat_rd_cnt(srd[1]), .stat_wr_cnt(swr[1])
  );

  int          n_vec = 0;
  int          n_bad = 0;
  int          lat [2] = '{4, 1};
  logic [31:0] model [2][1024];
  bit          known [2][1024];
  int          exp_rd [2] = '{0, 0};
  int          exp_wr [2] = '{0, 0};

  typedef struct {
    int          d;
    bit          w;
    logic [31:0] a;
    logic [31:0] dat;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] st(int c);
`ifdef MEM_STATS_EN
    return 32'(c);
`else
    return (c >= 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  // Counts edges until mem_ready is seen (bounded).
  task automatic wait_ready(int d, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!rdy[d] && n < 300);
  endtask

  task automatic no_ready(int d, int cycles, string name);
    int pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (rdy[d]) pulses++;
    end
    chk(name, 32'(pulses), 32'd0);
  endtask

  task automatic access(int d, bit w, logic [31:0] a, logic [31:0] dat,
                        logic [31:0] exp, string name);
    int n;
    int idx;
    req_w[d] = w;
    req_r[d] = !w;
    req_a[d] = a;
    req_d[d] = dat;
    wait_ready(d, n);
    chk({name, " latency"}, 32'(n), 32'(lat[d]));
    req_w[d] = 1'b0;
    req_r[d] = 1'b0;
    req_a[d] = $urandom;
    req_d[d] = $urandom;
    if (!w) chk({name, " rdata"}, rdat[d], exp);
    idx = int'(a[AW+1:2]);
    if (w) begin
      model[d][idx] = dat;
      known[d][idx] = 1'b1;
      exp_wr[d]++;
    end else begin
      exp_rd[d]++;
    end
    @(posedge clk); #1;
    chk({name, " single pulse"}, 32'(rdy[d]), 32'd0);
  endtask

  initial begin
    int n;
    int n2;
    tbl[0] = '{0, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0};
    tbl[1] = '{0, 1'b0, 32'h0000_0040, 32'h0,         32'hDEAD_BEEF};
    tbl[2] = '{0, 1'b1, 32'h0000_1004, 32'hA5A5_A5A5, 32'h0};
    tbl[3] = '{0, 1'b0, 32'h0000_0004, 32'h0,         32'hA5A5_A5A5};
    tbl[4] = '{1, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0};
    tbl[5] = '{1, 1'b0, 32'h0000_0040, 32'h0,         32'hDEAD_BEEF};
    tbl[6] = '{1, 1'b1, 32'h0000_2008, 32'h0BAD_F00D, 32'h0};
    tbl[7] = '{1, 1'b0, 32'h0000_0008, 32'h0,         32'h0BAD_F00D};

    for (int d = 0; d < 2; d++) begin
      req_r[d] = 1'b0; req_w[d] = 1'b0; req_a[d] = 32'h0; req_d[d] = 32'h0;
    end
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset ready d%0d", d), 32'(rdy[d]), 32'd0);
      chk($sformatf("reset data d%0d", d), rdat[d], 32'd0);
      chk($sformatf("reset rdcnt d%0d", d), srd[d], 32'd0);
      chk($sformatf("reset wrcnt d%0d", d), swr[d], 32'd0);
    end
    rstn = 1'b1;

    // Directed vectors
    for (int i = 0; i < 8; i++)
      access(tbl[i].d, tbl[i].w, tbl[i].a, tbl[i].dat, tbl[i].exp,
             $sformatf("vec%0d", i));

    // Simultaneous read+write to 0x80: write first, then the held read.
    for (int d = 0; d < 2; d++) begin
      req_w[d] = 1'b1; req_r[d] = 1'b1;
      req_a[d] = 32'h0000_0080; req_d[d] = 32'h1234_5678;
      wait_ready(d, n);
      chk($sformatf("rw write latency d%0d", d), 32'(n), 32'(lat[d]));
      req_w[d] = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("rw gap d%0d", d), 32'(rdy[d]), 32'd0);
      wait_ready(d, n);
      chk($sformatf("rw read latency d%0d", d), 32'(n), 32'(lat[d]));
      chk($sformatf("rw read data d%0d", d), rdat[d], 32'h1234_5678);
      req_r[d] = 1'b0;
      model[d][32] = 32'h1234_5678; known[d][32] = 1'b1;
      exp_wr[d]++; exp_rd[d]++;
      no_ready(d, 10, $sformatf("rw extra pulse d%0d", d));
    end

    // Read dropped after one BUSY cycle still completes exactly once.
    req_r[0] = 1'b1; req_a[0] = 32'h0000_0040;
    repeat (2) @(posedge clk);
    #1;
    req_r[0] = 1'b0;
    wait_ready(0, n2);
    chk("drop latency", 32'(2 + n2), 32'd4);
    chk("drop rdata", rdat[0], 32'hDEAD_BEEF);
    exp_rd[0]++;
    no_ready(0, 10, "drop extra pulse");

    // Reset during BUSY of a write: write discarded, no pulse.
    access(0, 1'b1, 32'h0000_0010, 32'h7, 32'h0, "pre-reset write");
    req_w[0] = 1'b1; req_a[0] = 32'h0000_0010; req_d[0] = 32'h1;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b0;
    req_w[0] = 1'b0;
    @(posedge clk); #1;
    chk("mid-reset ready", 32'(rdy[0]), 32'd0);
    chk("mid-reset data", rdat[0], 32'd0);
    rstn = 1'b1;
    exp_rd = '{0, 0};
    exp_wr = '{0, 0};
    no_ready(0, 8, "post-reset pulse");
    access(0, 1'b0, 32'h0000_0010, 32'h0, 32'h7, "post-reset read");

    // LATENCY=1 back-to-back: 2 writes + 3 reads, then the counters.
    access(1, 1'b1, 32'h0000_0100, 32'h1111_0000, 32'h0, "b2b w0");
    access(1, 1'b1, 32'h0000_0104, 32'h2222_0000, 32'h0, "b2b w1");
    access(1, 1'b0, 32'h0000_0100, 32'h0, 32'h1111_0000, "b2b r0");
    access(1, 1'b0, 32'h0000_0104, 32'h0, 32'h2222_0000, "b2b r1");
    access(1, 1'b0, 32'h0000_0100, 32'h0, 32'h1111_0000, "b2b r2");
    chk("b2b rdcnt", srd[1], st(3));
    chk("b2b wrcnt", swr[1], st(2));

    // Random traffic against the reference memory, with aliased addresses.
    for (int i = 0; i < 300; i++) begin
      int d;
      int idx;
      bit w;
      logic [31:0] a;
      d   = int'($urandom_range(0, 1));
      idx = int'($urandom_range(0, 15));
      a   = $urandom;
      a[AW+1:2] = idx[AW-1:0];
      w   = ($urandom_range(0, 1) == 1) || !known[d][idx];
      access(d, w, a, $urandom, model[d][idx], $sformatf("rand%0d", i));
    end
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("final rdcnt d%0d", d), srd[d], st(exp_rd[d]));
      chk($sformatf("final wrcnt d%0d", d), swr[d], st(exp_wr[d]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
